// File: rtl/pll_lock_sequencer.sv
// PLL power-up / lock-recovery sequencer: reset hold, lock wait with timeout, stability check, retry/fault.
// Optional lock-loss event counter enabled by defining PLL_SEQ_LOSS_COUNT_EN.
module pll_lock_sequencer #(
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       piul1Clock,
  input  logic       piul1Reset,
  input  logic       piul1Locked,
  input  logic       piul1Restart,
  output logic       poul1PllReset,
  output logic       poul1DomainReset,
  output logic       poul1Ready,
  output logic       poul1Fault,
  output logic [2:0] poul3State,
  output logic [7:0] poul8LossCount
);

  localparam int MAX_AB  = (RESET_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RESET_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_ABC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_ABC > 1) ? $clog2(MAX_ABC) : 1;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [3:0]         retry_reg, retry_next;
  logic [3:0]         retry_inc;
  logic [1:0]         sync_reg;
  logic               lock_sync;
  logic               loss_event;
  logic               pll_reset_reg, domain_reset_reg, ready_reg, fault_reg;
  logic               pll_reset_next, domain_reset_next, ready_next, fault_next;

  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], piul1Locked};
    end
  end

  assign lock_sync = sync_reg[1];
  assign retry_inc = retry_reg + 4'd1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    loss_event = 1'b0;
    if (piul1Restart) begin
      state_next = RESET_PLL;
      cnt_next   = '0;
      retry_next = 4'd0;
    end else begin
      case (state_reg)
        RESET_PLL: begin
          if (cnt_reg == CNT_W'(RESET_HOLD_CYCLES - 1)) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_sync) begin
            state_next = STABILIZE;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            cnt_next   = '0;
            retry_next = retry_inc;
            state_next = (retry_inc == 4'(MAX_RETRIES)) ? FAULT : RESET_PLL;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        STABILIZE: begin
          // A dropout here restarts the lock wait without charging a retry.
          if (!lock_sync) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            state_next = RUN;
            cnt_next   = '0;
            retry_next = 4'd0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_sync) begin
            state_next = RESET_PLL;
            cnt_next   = '0;
            loss_event = 1'b1;
          end
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = RESET_PLL;
          cnt_next   = '0;
          retry_next = 4'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they update on the same edge as the state.
  always_comb begin
    pll_reset_next    = 1'b1;
    domain_reset_next = 1'b1;
    ready_next        = 1'b0;
    fault_next        = 1'b0;
    case (state_next)
      WAIT_LOCK, STABILIZE: pll_reset_next = 1'b0;
      RUN: begin
        pll_reset_next    = 1'b0;
        domain_reset_next = 1'b0;
        ready_next        = 1'b1;
      end
      FAULT:   fault_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state_reg        <= RESET_PLL;
      cnt_reg          <= '0;
      retry_reg        <= 4'd0;
      pll_reset_reg    <= 1'b1;
      domain_reset_reg <= 1'b1;
      ready_reg        <= 1'b0;
      fault_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      retry_reg        <= retry_next;
      pll_reset_reg    <= pll_reset_next;
      domain_reset_reg <= domain_reset_next;
      ready_reg        <= ready_next;
      fault_reg        <= fault_next;
    end
  end

  assign poul1PllReset    = pll_reset_reg;
  assign poul1DomainReset = domain_reset_reg;
  assign poul1Ready       = ready_reg;
  assign poul1Fault       = fault_reg;
  assign poul3State       = state_reg;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] loss_reg;

  // Saturating; restart deliberately leaves it alone.
  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      loss_reg <= 8'd0;
    end else if (loss_event && (loss_reg != 8'hff)) begin
      loss_reg <= loss_reg + 8'd1;
    end
  end

  assign poul8LossCount = loss_reg;
`else
  logic unused_loss_event;

  assign unused_loss_event = loss_event;
  assign poul8LossCount    = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with a queue scoreboard of expected output snapshots.
module tb_pll_lock_sequencer;

  localparam int HOLD    = 4;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 32;
  localparam int RETRIES = 2;

  logic       clk;
  logic       srst;
  logic       locked;
  logic       restart;
  logic       pll_reset;
  logic       domain_reset;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [7:0] loss_count;

  int         checks;
  int         failures;
  int         exp_loss;
  string      tag_q[$];
  logic [14:0] exp_q[$];

  pll_lock_sequencer #(
    .RESET_HOLD_CYCLES  (HOLD),
    .LOCK_STABLE_CYCLES (STABLE),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRIES        (RETRIES)
  ) dut (
    .piul1Clock      (clk),
    .piul1Reset      (srst),
    .piul1Locked     (locked),
    .piul1Restart    (restart),
    .poul1PllReset   (pll_reset),
    .poul1DomainReset(domain_reset),
    .poul1Ready      (ready),
    .poul1Fault      (fault),
    .poul3State      (state),
    .poul8LossCount  (loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Everything is driven and sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected outputs come from the per-state output table.
  task automatic push(input string tag, input logic [2:0] st);
    logic [3:0] flags;
    case (st)
      3'd0:    flags = 4'b1100;
      3'd1:    flags = 4'b0100;
      3'd2:    flags = 4'b0100;
      3'd3:    flags = 4'b0010;
      3'd4:    flags = 4'b1101;
      default: flags = 4'b0000;
    endcase
    tag_q.push_back(tag);
    exp_q.push_back({flags, st, exp_loss[7:0]});
  endtask

  task automatic check();
    logic [14:0] obs;
    logic [14:0] e;
    string       t;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {pll_reset, domain_reset, ready, fault, state, loss_count};
      checks++;
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed={pll,dom,rdy,flt,st,loss}=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic expect_state(input string tag, input logic [2:0] st);
    push(tag, st);
    check();
  endtask

  task automatic note_loss();
`ifdef PLL_SEQ_LOSS_COUNT_EN
    if (exp_loss != 255) exp_loss++;
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_loss = 0;
    srst     = 1'b1;
    locked   = 1'b1;
    restart  = 1'b0;

    // Reset state
    tick(3);
    expect_state("reset", 3'd0);

    // Cold start with lock already high: Ready 13 cycles after release
    srst = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      logic [2:0] st;
      tick(1);
      st = (c < HOLD) ? 3'd0 : (c == HOLD) ? 3'd1 : (c < HOLD + 1 + STABLE) ? 3'd2 : 3'd3;
      expect_state($sformatf("cold_c%0d", c), st);
    end

    // Lock drops in RUN: 3-cycle reaction, relock, saturating loss count
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      tick(2);
      expect_state($sformatf("drop%0d_t2", i), 3'd3);
      tick(1);
      note_loss();
      expect_state($sformatf("drop%0d_t3", i), 3'd0);
      locked = 1'b1;
      tick(13);
      expect_state($sformatf("relock%0d", i), 3'd3);
    end

    // Restart from RUN keeps LossCount; then lock chatter
    restart = 1'b1;
    locked  = 1'b0;
    tick(1);
    restart = 1'b0;
    expect_state("rst_run_r0", 3'd0);
    tick(4);  expect_state("chat_r4", 3'd1);
    tick(2);  locked = 1'b1;
    tick(3);  expect_state("chat_r9", 3'd2);
    tick(2);  locked = 1'b0;
    tick(1);  locked = 1'b1;
    tick(1);  expect_state("chat_r13", 3'd2);
    tick(1);  expect_state("chat_r14", 3'd1);
    tick(1);  expect_state("chat_r15", 3'd2);
    tick(7);  expect_state("chat_r22", 3'd2);
    tick(1);  expect_state("chat_r23", 3'd3);

    // Lock never arrives: two timeout windows then FAULT
    restart = 1'b1;
    locked  = 1'b0;
    tick(1);
    restart = 1'b0;
    expect_state("nl_r0", 3'd0);
    tick(3);   expect_state("nl_r3", 3'd0);
    tick(1);   expect_state("nl_r4", 3'd1);
    tick(31);  expect_state("nl_r35", 3'd1);
    tick(1);   expect_state("nl_r36", 3'd0);
    tick(3);   expect_state("nl_r39", 3'd0);
    tick(1);   expect_state("nl_r40", 3'd1);
    tick(31);  expect_state("nl_r71", 3'd1);
    tick(1);   expect_state("nl_r72", 3'd4);
    tick(100); expect_state("nl_hold", 3'd4);

    // Restart in FAULT clears retries: full two-window sequence repeats
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    expect_state("rf_r0", 3'd0);
    tick(36); expect_state("rf_r36", 3'd0);
    tick(36); expect_state("rf_r72", 3'd4);

    // One retry used, reach STABILIZE, restart there: retries must be cleared
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    expect_state("rs_r0", 3'd0);
    tick(35); expect_state("rs_r35", 3'd1);
    tick(1);  expect_state("rs_r36", 3'd0);
    locked = 1'b1;
    tick(5);  expect_state("rs_r41", 3'd2);
    tick(1);  expect_state("rs_r42", 3'd2);
    restart = 1'b1;
    locked  = 1'b0;
    tick(1);
    restart = 1'b0;
    expect_state("rs2_r0", 3'd0);
    tick(36); expect_state("rs2_r36", 3'd0);
    tick(4);  expect_state("rs2_r40", 3'd1);
    tick(32); expect_state("rs2_r72", 3'd4);

    // Back to RUN, then reset and restart together
    restart = 1'b1;
    locked  = 1'b1;
    tick(1);
    restart = 1'b0;
    expect_state("rr_r0", 3'd0);
    tick(13); expect_state("rr_r13", 3'd3);
    srst    = 1'b1;
    restart = 1'b1;
    tick(1);
    exp_loss = 0;
    expect_state("srst_restart", 3'd0);
    srst    = 1'b0;
    restart = 1'b0;
    tick(13); expect_state("post_rst_run", 3'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
